pc_reg: RTL and testbench



---
 rtl/mips_pkg.sv | 20 ++
 rtl/pc_reg_if.sv | 27 ++
 rtl/pc_reg.sv | 85 ++++++++
 tb/tb_pc_reg.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Types and constants shared by the PC register, next-PC logic and decoder.
package mips_pkg;

  typedef enum logic [1:0] {
    INCREMENT = 2'b00,
    BRANCH    = 2'b01,
    JUMP      = 2'b10,
    JR        = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DELAY  = 2'b01,
    HALTED = 2'b10
  } pc_state_t;

  localparam logic [31:0] RESET_VECTOR_C = 32'hBFC00000;
  localparam logic [31:0] HALT_ADDR_C    = 32'h00000000;

endpackage

// File: rtl/pc_reg_if.sv
// Bundle between the PC register stage and the surrounding fetch/next-PC logic.
interface pc_reg_if;
  import mips_pkg::*;

  // Flow control: there is no valid/ready pair. stall=1 freezes every register
  // of the stage for that edge (except once halted, where nothing moves anyway).
  logic        stall;
  pc_sel_t     pc_sel;
  logic        is_true;
  logic [31:0] pcnext;
  logic [31:0] pc;
  logic        active;
  logic        in_delay_slot;
  logic        redirect_ignored;
  pc_state_t   state;

  modport master (
    output stall, pc_sel, is_true, pcnext,
    input  pc, active, in_delay_slot, redirect_ignored, state
  );

  modport slave (
    input  stall, pc_sel, is_true, pcnext,
    output pc, active, in_delay_slot, redirect_ignored, state
  );

endinterface

// File: rtl/pc_reg.sv
// Program-counter stage: sequential PC, one-instruction branch delay slot,
// stall hold, and halt after a redirect to HALT_ADDR.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_C,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_C
) (
  input logic       clk,
  input logic       reset,
  pc_reg_if.slave   bus
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        active_q, active_d;
  logic        ignored_q, ignored_d;
  logic        redirect;

  always_comb begin
    redirect  = (bus.pc_sel == JUMP) || (bus.pc_sel == JR) ||
                ((bus.pc_sel == BRANCH) && bus.is_true);
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    active_d  = active_q;
    ignored_d = 1'b0;

    case (state_q)
      RUN: begin
        if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
          if (redirect) begin
            target_d = bus.pcnext;
            state_d  = DELAY;
          end
        end
      end
      DELAY: begin
        if (!bus.stall) begin
          pc_d      = target_q;
          // A second redirect from the delay slot cannot be honoured; flag it.
          ignored_d = redirect;
          if (target_q == HALT_ADDR) begin
            state_d  = HALTED;
            active_d = 1'b0;
          end else begin
            state_d = RUN;
          end
        end
      end
      HALTED: begin
        pc_d     = HALT_ADDR;
        active_d = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_VECTOR;
      target_q  <= 32'd0;
      active_q  <= 1'b1;
      ignored_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      target_q  <= target_d;
      active_q  <= active_d;
      ignored_q <= ignored_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.active           = active_q;
  assign bus.in_delay_slot    = (state_q == DELAY);
  assign bus.redirect_ignored = ignored_q;
  assign bus.state            = state_q;

endmodule

// File: tb/tb_pc_reg.sv
// Self-checking bench for pc_reg: directed sequences plus a random stall run.
module tb_pc_reg;
  import mips_pkg::*;

  logic clk;
  logic reset;
  pc_reg_if bus();

  pc_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;
  // {pc, active, in_delay_slot, redirect_ignored}
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [34:0] e);
    check({tag, ".pc"}, bus.pc, e[34:3]);
    check({tag, ".active"}, {31'd0, bus.active}, {31'd0, e[2]});
    check({tag, ".delay"}, {31'd0, bus.in_delay_slot}, {31'd0, e[1]});
    check({tag, ".ignored"}, {31'd0, bus.redirect_ignored}, {31'd0, e[0]});
  endtask

  // Driver: apply inputs mid-cycle, queue what should appear after the edge.
  task automatic step(input string tag, input pc_sel_t sel, input logic tr,
                      input logic [31:0] nxt, input logic stl,
                      input logic [31:0] e_pc, input logic e_act,
                      input logic e_ds, input logic e_ri);
    logic [34:0] e;
    bus.pc_sel  = sel;
    bus.is_true = tr;
    bus.pcnext  = nxt;
    bus.stall   = stl;
    exp_q.push_back({e_pc, e_act, e_ds, e_ri});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_outputs(tag, e);
  endtask

  task automatic do_reset(input string tag);
    #1;
    reset = 1'b1;
    #1;
    check_outputs(tag, {32'hBFC00000, 1'b1, 1'b0, 1'b0});
    @(posedge clk);
    #2;
    reset = 1'b0;
    bus.pc_sel  = INCREMENT;
    bus.stall   = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++)
      step("inc", INCREMENT, 1'b0, 32'hDEADBEEF, 1'b0,
           bus.pc + 32'd4, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] model_pc;
    reset       = 1'b1;
    bus.stall   = 1'b0;
    bus.pc_sel  = INCREMENT;
    bus.is_true = 1'b0;
    bus.pcnext  = 32'd0;
    @(posedge clk);
    #1;
    do_reset("reset0");

    // Plain increment
    step("inc1", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("inc2", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00008, 1'b1, 1'b0, 1'b0);
    step("inc3", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC0000C, 1'b1, 1'b0, 1'b0);
    step("stall_run", JUMP, 1'b0, 32'h1234, 1'b1, 32'hBFC0000C, 1'b1, 1'b0, 1'b0);

    // Jump with delay slot
    do_reset("reset_jump");
    step("j_pre", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("j_ds", JUMP, 1'b0, 32'hBFC00100, 1'b0, 32'hBFC00008, 1'b1, 1'b1, 1'b0);
    step("j_tgt", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00100, 1'b1, 1'b0, 1'b0);

    // Branch not taken, then taken
    do_reset("reset_br");
    step("b_p1", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("b_p2", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00008, 1'b1, 1'b0, 1'b0);
    step("b_p3", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC0000C, 1'b1, 1'b0, 1'b0);
    step("b_p4", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00010, 1'b1, 1'b0, 1'b0);
    step("b_nt", BRANCH, 1'b0, 32'hBFC00080, 1'b0, 32'hBFC00014, 1'b1, 1'b0, 1'b0);
    step("b_ds", BRANCH, 1'b1, 32'hBFC00040, 1'b0, 32'hBFC00018, 1'b1, 1'b1, 1'b0);
    step("b_tgt", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00040, 1'b1, 1'b0, 1'b0);

    // JR to zero with stall in the delay slot, then halt
    do_reset("reset_halt");
    incs(8);
    check("halt_start", bus.pc, 32'hBFC00020);
    step("jr_ds", JR, 1'b0, 32'h00000000, 1'b0, 32'hBFC00024, 1'b1, 1'b1, 1'b0);
    step("ds_stall1", INCREMENT, 1'b0, 32'hBFC00400, 1'b1, 32'hBFC00024, 1'b1, 1'b1, 1'b0);
    step("ds_stall2", INCREMENT, 1'b0, 32'hBFC00400, 1'b1, 32'hBFC00024, 1'b1, 1'b1, 1'b0);
    step("halt", INCREMENT, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
    step("halt_j", JUMP, 1'b0, 32'hBFC00100, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
    step("halt_sj", JUMP, 1'b0, 32'hBFC00100, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
    step("halt_i", INCREMENT, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);

    // Redirect inside the delay slot is dropped
    do_reset("reset_ign");
    step("i_pre", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("i_j1", JUMP, 1'b0, 32'hBFC00200, 1'b0, 32'hBFC00008, 1'b1, 1'b1, 1'b0);
    step("i_j2", JUMP, 1'b0, 32'hBFC00300, 1'b0, 32'hBFC00200, 1'b1, 1'b0, 1'b1);
    step("i_after", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00204, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a delay slot
    do_reset("reset_async_pre");
    step("a_pre", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("a_ds", JUMP, 1'b0, 32'hBFC00500, 1'b0, 32'hBFC00008, 1'b1, 1'b1, 1'b0);
    do_reset("reset_async_mid");
    step("a_r1", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00004, 1'b1, 1'b0, 1'b0);
    step("a_r2", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hBFC00008, 1'b1, 1'b0, 1'b0);

    // 32-bit wrap does not halt
    do_reset("reset_wrap");
    step("w_ds", JUMP, 1'b0, 32'hFFFFFFF8, 1'b0, 32'hBFC00004, 1'b1, 1'b1, 1'b0);
    step("w_t", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hFFFFFFF8, 1'b1, 1'b0, 1'b0);
    step("w_fc", INCREMENT, 1'b0, 32'h0, 1'b0, 32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    step("w_0", INCREMENT, 1'b0, 32'h0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
    step("w_4", INCREMENT, 1'b0, 32'h0, 1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0);

    // Random stalls over sequential fetch and not-taken branches
    do_reset("reset_rand");
    model_pc = 32'hBFC00000;
    for (int i = 0; i < 40; i++) begin
      logic stl;
      pc_sel_t sel;
      stl = ($urandom_range(0, 2) == 0);
      sel = ($urandom_range(0, 1) == 0) ? INCREMENT : BRANCH;
      if (!stl) model_pc = model_pc + 32'd4;
      step("rand", sel, 1'b0, $urandom, stl, model_pc, 1'b1, 1'b0, 1'b0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
